// File: rtl/mc_pkg.sv
// mc_pkg: shared constants for the multicycle controller.
//   - opcode / funct field values of the supported instruction set
//   - FSM state enum (codes are externally visible on State)
//   - ALU control codes, AluSrcB and Pcsrc mux encodings
//   - instruction class enum produced by mc_decode
package mc_pkg;

  // Opcode field values
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // Funct field values (Op == OP_RTYPE)
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_JR  = 6'b001000;

  // ALU control codes (cast to ALUC_W at the point of use)
  localparam int unsigned ALUC_ADD = 0;
  localparam int unsigned ALUC_AND = 1;
  localparam int unsigned ALUC_XOR = 2;
  localparam int unsigned ALUC_SLL = 3;
  localparam int unsigned ALUC_SUB = 4;
  localparam int unsigned ALUC_OR  = 5;
  localparam int unsigned ALUC_LUI = 6;
  localparam int unsigned ALUC_SRL = 7;
  localparam int unsigned ALUC_SRA = 15;

  // ALU operand B select
  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

  // Next-PC select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_REGA   = 2'b10;
  localparam logic [1:0] PCSRC_JUMP   = 2'b11;

  typedef enum logic [2:0] {
    ST_IF  = 3'd0,
    ST_ID  = 3'd1,
    ST_EXE = 3'd2,
    ST_MEM = 3'd3,
    ST_WB  = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    CL_ILLEGAL,
    CL_RALU,    // add sub and or xor
    CL_SHIFT,   // sll srl sra
    CL_JR,
    CL_IMM,     // addi andi ori xori lui
    CL_LW,
    CL_SW,
    CL_BEQ,
    CL_BNE,
    CL_J,
    CL_JAL
  } iclass_e;

endpackage

// File: rtl/mc_decode.sv
// mc_decode: purely combinational instruction classification.
//   op_i, func_i  : opcode / funct fields from the instruction register
//   iclass_o      : instruction class (CL_ILLEGAL when unsupported)
//   aluc_o        : ALU code for R-type and immediate ALU operations
//   sext_imm_o    : immediate is sign-extended in EXE (addi only)
//   legal_o       : instruction belongs to the supported set
module mc_decode
  import mc_pkg::*;
#(
  parameter int unsigned ALUC_W = 4
) (
  input  logic [5:0]        op_i,
  input  logic [5:0]        func_i,
  output iclass_e           iclass_o,
  output logic [ALUC_W-1:0] aluc_o,
  output logic              sext_imm_o,
  output logic              legal_o
);

  always_comb begin
    iclass_o   = CL_ILLEGAL;
    aluc_o     = '0;
    sext_imm_o = 1'b0;
    case (op_i)
      OP_RTYPE: begin
        case (func_i)
          FN_ADD: begin iclass_o = CL_RALU;  aluc_o = ALUC_W'(ALUC_ADD); end
          FN_SUB: begin iclass_o = CL_RALU;  aluc_o = ALUC_W'(ALUC_SUB); end
          FN_AND: begin iclass_o = CL_RALU;  aluc_o = ALUC_W'(ALUC_AND); end
          FN_OR:  begin iclass_o = CL_RALU;  aluc_o = ALUC_W'(ALUC_OR);  end
          FN_XOR: begin iclass_o = CL_RALU;  aluc_o = ALUC_W'(ALUC_XOR); end
          FN_SLL: begin iclass_o = CL_SHIFT; aluc_o = ALUC_W'(ALUC_SLL); end
          FN_SRL: begin iclass_o = CL_SHIFT; aluc_o = ALUC_W'(ALUC_SRL); end
          FN_SRA: begin iclass_o = CL_SHIFT; aluc_o = ALUC_W'(ALUC_SRA); end
          FN_JR:  iclass_o = CL_JR;
          default: ;
        endcase
      end
      OP_ADDI: begin
        iclass_o   = CL_IMM;
        aluc_o     = ALUC_W'(ALUC_ADD);
        sext_imm_o = 1'b1;
      end
      OP_ANDI: begin iclass_o = CL_IMM; aluc_o = ALUC_W'(ALUC_AND); end
      OP_ORI:  begin iclass_o = CL_IMM; aluc_o = ALUC_W'(ALUC_OR);  end
      OP_XORI: begin iclass_o = CL_IMM; aluc_o = ALUC_W'(ALUC_XOR); end
      OP_LUI:  begin iclass_o = CL_IMM; aluc_o = ALUC_W'(ALUC_LUI); end
      OP_LW:   iclass_o = CL_LW;
      OP_SW:   iclass_o = CL_SW;
      OP_BEQ:  iclass_o = CL_BEQ;
      OP_BNE:  iclass_o = CL_BNE;
      OP_J:    iclass_o = CL_J;
      OP_JAL:  iclass_o = CL_JAL;
      default: ;
    endcase
  end

  assign legal_o = (iclass_o != CL_ILLEGAL);

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: IF/ID/EXE/MEM/WB control FSM for a multicycle MIPS-like
// datapath with a unified memory.
//   Clk, Clrn             : clock, asynchronous active-low reset
//   Op, Func, Zero        : IR fields and ALU zero flag
//   MemReady              : memory access completes this cycle
//   Wpc, Wir, Wmem, Wreg  : write enables (forced low while Clrn is low)
//   Iord, AluSrcA/B, Aluc, Pcsrc, Shift, Regrt, Sext, M2reg, Jal : datapath
//   State                 : current state code; Illegal : undecodable in ID
// All outputs are combinational from State and the inputs.
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int unsigned ALUC_W      = 4,
  parameter bit          MEM_WAIT_EN = 1'b1
) (
  input  logic              Clk,
  input  logic              Clrn,
  input  logic [5:0]        Op,
  input  logic [5:0]        Func,
  input  logic              Zero,
  input  logic              MemReady,
  output logic              Wpc,
  output logic              Wir,
  output logic              Wmem,
  output logic              Wreg,
  output logic              Iord,
  output logic              AluSrcA,
  output logic [1:0]        AluSrcB,
  output logic [ALUC_W-1:0] Aluc,
  output logic [1:0]        Pcsrc,
  output logic              Shift,
  output logic              Regrt,
  output logic              Sext,
  output logic              M2reg,
  output logic              Jal,
  output logic [2:0]        State,
  output logic              Illegal
);

  state_e            state_q, state_d;
  iclass_e           iclass;
  logic [ALUC_W-1:0] dec_aluc;
  logic              dec_sext_imm;
  logic              dec_legal;
  logic              mem_rdy;
  logic              wpc_raw, wir_raw, wmem_raw, wreg_raw, illegal_raw;

  mc_decode #(.ALUC_W(ALUC_W)) u_decode (
    .op_i       (Op),
    .func_i     (Func),
    .iclass_o   (iclass),
    .aluc_o     (dec_aluc),
    .sext_imm_o (dec_sext_imm),
    .legal_o    (dec_legal)
  );

  assign mem_rdy = MEM_WAIT_EN ? MemReady : 1'b1;

  // State register
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) state_q <= ST_IF;
    else       state_q <= state_d;
  end

  // Next-state logic; unreachable codes behave as IF
  always_comb begin
    state_d = ST_IF;
    case (state_q)
      ST_ID: begin
        case (iclass)
          CL_J, CL_JAL, CL_JR, CL_ILLEGAL: state_d = ST_IF;
          default:                         state_d = ST_EXE;
        endcase
      end
      ST_EXE: begin
        case (iclass)
          CL_LW, CL_SW:   state_d = ST_MEM;
          CL_BEQ, CL_BNE: state_d = ST_IF;
          default:        state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (!mem_rdy)              state_d = ST_MEM;
        else if (iclass == CL_LW)  state_d = ST_WB;
        else                       state_d = ST_IF;
      end
      ST_WB:   state_d = ST_IF;
      default: state_d = mem_rdy ? ST_ID : ST_IF;
    endcase
  end

  // Output logic; unreachable codes behave as IF
  always_comb begin
    wpc_raw     = 1'b0;
    wir_raw     = 1'b0;
    wmem_raw    = 1'b0;
    wreg_raw    = 1'b0;
    illegal_raw = 1'b0;
    Iord        = 1'b0;
    AluSrcA     = 1'b0;
    AluSrcB     = SRCB_REGB;
    Aluc        = '0;
    Pcsrc       = PCSRC_ALU;
    Shift       = 1'b0;
    Regrt       = 1'b0;
    Sext        = 1'b0;
    M2reg       = 1'b0;
    Jal         = 1'b0;
    case (state_q)
      ST_ID: begin
        // ALU computes the branch target while the instruction decodes
        AluSrcB = SRCB_IMM_SL2;
        Sext    = 1'b1;
        Aluc    = ALUC_W'(ALUC_ADD);
        case (iclass)
          CL_J: begin
            wpc_raw = 1'b1;
            Pcsrc   = PCSRC_JUMP;
          end
          CL_JAL: begin
            wpc_raw  = 1'b1;
            Pcsrc    = PCSRC_JUMP;
            wreg_raw = 1'b1;
            Jal      = 1'b1;
          end
          CL_JR: begin
            wpc_raw = 1'b1;
            Pcsrc   = PCSRC_REGA;
          end
          default: ;
        endcase
        illegal_raw = !dec_legal;
      end
      ST_EXE: begin
        AluSrcA = 1'b1;
        case (iclass)
          CL_BEQ, CL_BNE: begin
            Aluc    = ALUC_W'(ALUC_SUB);
            Pcsrc   = PCSRC_BRANCH;
            wpc_raw = (iclass == CL_BEQ) ? Zero : !Zero;
          end
          CL_LW, CL_SW: begin
            AluSrcB = SRCB_IMM;
            Sext    = 1'b1;
            Aluc    = ALUC_W'(ALUC_ADD);
          end
          CL_IMM: begin
            AluSrcB = SRCB_IMM;
            Sext    = dec_sext_imm;
            Aluc    = dec_aluc;
          end
          default: begin
            Shift = (iclass == CL_SHIFT);
            Aluc  = dec_aluc;
          end
        endcase
      end
      ST_MEM: begin
        Iord     = 1'b1;
        wmem_raw = (iclass == CL_SW) && mem_rdy;
      end
      ST_WB: begin
        wreg_raw = 1'b1;
        Regrt    = (iclass == CL_IMM) || (iclass == CL_LW);
        M2reg    = (iclass == CL_LW);
      end
      default: begin
        AluSrcB = SRCB_FOUR;
        Aluc    = ALUC_W'(ALUC_ADD);
        wpc_raw = mem_rdy;
        wir_raw = mem_rdy;
      end
    endcase
  end

  // Reset gates the write enables directly so nothing is written while
  // Clrn is low, even though State already reads IF.
  assign Wpc     = wpc_raw     & Clrn;
  assign Wir     = wir_raw     & Clrn;
  assign Wmem    = wmem_raw    & Clrn;
  assign Wreg    = wreg_raw    & Clrn;
  assign Illegal = illegal_raw & Clrn;
  assign State   = state_q;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter ALUC_W, default 4, width of ALU control code Aluc.
REQ-002 Parameter MEM_WAIT_EN, default 1; 1 = honour MemReady, 0 = treat MemReady as always 1.
REQ-003 Clk  in  1  sole clock; all state updates on rising edge.
REQ-004 Clrn  in  1  reset, asynchronous, active-low.
REQ-005 Op  in  6  instruction opcode field from instruction register.
REQ-006 Func  in  6  instruction funct field.
REQ-007 Zero  in  1  ALU result-equals-zero flag.
REQ-008 MemReady  in  1  unified memory access complete this cycle.
REQ-009 Wpc, Wir, Wmem, Wreg  out  1 each  PC, IR, data-memory and register-file write enables.
REQ-010 Iord  out  1  memory address select: 0 = PC, 1 = ALU result.
REQ-011 AluSrcA  out  1  0 = PC, 1 = register A.
REQ-012 AluSrcB  out  2  00 = reg B, 01 = constant 4, 10 = ext imm, 11 = ext imm << 2.
REQ-013 Aluc  out  ALUC_W  ALU code: add 0, and 1, xor 2, sll 3, sub 4, or 5, lui 6, srl 7, sra 15.
REQ-014 Pcsrc  out  2  00 = ALU, 01 = branch target register, 10 = reg A (jr), 11 = jump address.
REQ-015 Shift, Regrt, Sext, M2reg, Jal  out  1 each  same meanings as single-cycle control.
REQ-016 State  out  3  current FSM state code; Illegal  out  1  one-cycle pulse on undecodable instruction.

Function
REQ-017 FSM states SHALL be IF=0, ID=1, EXE=2, MEM=3, WB=4; codes 5-7 unreachable, decoded as IF.
REQ-018 IF: Iord=0, AluSrcA=0, AluSrcB=01, Aluc=add; when MemReady: Wpc=Wir=1, Pcsrc=00, next ID; else all writes 0, stay IF.
REQ-019 ID: AluSrcA=0, AluSrcB=11, Sext=1, Aluc=add (branch target latched externally); j: Wpc=1, Pcsrc=11, next IF.
REQ-020 ID, jal: Wpc=1, Pcsrc=11, Wreg=1, Jal=1, next IF; jr (Op 0, Func 001000): Wpc=1, Pcsrc=10, next IF.
REQ-021 ID, opcode/funct outside supported set (add, sub, and, or, xor, sll, srl, sra, jr, addi, andi, ori, xori, lui, lw, sw, beq, bne, j, jal): Illegal=1, no writes, next IF.
REQ-022 ID, all other legal instructions: next EXE.
REQ-023 EXE, beq/bne: AluSrcA=1, AluSrcB=00, Aluc=sub, Pcsrc=01, Wpc=Zero (beq) or ~Zero (bne), next IF.
REQ-024 EXE, lw/sw: AluSrcA=1, AluSrcB=10, Sext=1, Aluc=add, next MEM.
REQ-025 EXE, R-type: AluSrcA=1, AluSrcB=00, Shift=1 for sll/srl/sra, Aluc per funct; immediates: AluSrcB=10, Sext=1 for addi only; next WB.
REQ-026 MEM: Iord=1; sw: Wmem=MemReady, next IF when MemReady; lw: next WB when MemReady; otherwise hold MEM with Wmem=0.
REQ-027 WB: Wreg=1; Regrt=1 for immediates/lw, 0 for R-type; M2reg=1 for lw only; next IF.
REQ-028 Latency in cycles with MemReady=1: jump 2, branch 3, R/immediate 4, sw 4, lw 5.
REQ-029 Outputs SHALL be combinational from State, Op, Func, Zero, MemReady; unlisted outputs 0 in each state.
REQ-030 Op/Func SHALL be sampled only combinationally; IR stability from ID through WB is guaranteed by Wir=0 outside IF.

Reset
REQ-031 Clrn low SHALL force State=IF immediately and hold Wpc, Wir, Wmem, Wreg, Illegal at 0 while asserted.
REQ-032 Reset mid-instruction SHALL abandon it without any further write; first IF fetch follows Clrn release.

Structure
REQ-033 Package mc_pkg SHALL hold opcode/funct constants, state enum, Aluc codes and AluSrcB/Pcsrc encodings.
REQ-034 One sub-module mc_decode (combinational instruction classification: class, Aluc, legality) SHALL be instantiated; FSM in top.

Verification
REQ-035 add $3,$1,$2 (Op 0, Func 100000), MemReady=1 -> States 0,1,2,4, Wreg=1 only in WB, Aluc=0, Regrt=0.
REQ-036 lw with MemReady low 3 cycles in MEM -> MEM held 4 cycles, then WB with M2reg=1, Wreg=1; total 8 cycles.
REQ-037 beq Zero=1 -> EXE Wpc=1, Pcsrc=01; bne Zero=1 -> EXE Wpc=0; both return to IF, latency 3.
REQ-038 Op 111111 -> Illegal=1 in ID for one cycle, no write enable asserted, next State=0.
REQ-039 Clrn low during MEM of sw -> Wmem=0 immediately, State=0; after release fetch resumes with Wpc=Wir=1.
